// File: rtl/mem_arbiter_2p_if.sv
// Bus bundle between the two requesters, the memory block and mem_arbiter_2p.
// master = requester/memory side, slave = arbiter side.
interface mem_arbiter_2p_if #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 8
) ();
  logic                    req0;
  logic                    we0;
  logic [ADDRESS_SIZE-1:0] addr0;
  logic [WORD_SIZE-1:0]    wdata0;
  logic                    lock0;
  logic                    gnt0;
  logic                    rvalid0;
  logic [WORD_SIZE-1:0]    rdata0;

  logic                    req1;
  logic                    we1;
  logic [ADDRESS_SIZE-1:0] addr1;
  logic [WORD_SIZE-1:0]    wdata1;
  logic                    lock1;
  logic                    gnt1;
  logic                    rvalid1;
  logic [WORD_SIZE-1:0]    rdata1;

  logic [ADDRESS_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0]    mem_w_data;
  logic                    mem_w_en;
  logic [WORD_SIZE-1:0]    mem_r_data;

  modport master (
    output req0, we0, addr0, wdata0, lock0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, addr1, wdata1, lock1,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_w_data, mem_w_en,
    output mem_r_data
  );

  modport slave (
    input  req0, we0, addr0, wdata0, lock0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, addr1, wdata1, lock1,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_w_data, mem_w_en,
    input  mem_r_data
  );
endinterface

// File: rtl/mem_arbiter_2p.sv
// Two-requester arbiter for the single-port data memory: round-robin, one access per
// cycle, bounded bus lock. Define ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module mem_arbiter_2p #(
  parameter int WORD_SIZE    = 8,
  parameter int ADDRESS_SIZE = 8,
  parameter int LOCK_MAX     = 16
) (
  input  logic             clk,
  input  logic             rst,
  mem_arbiter_2p_if.slave  bus
);

  localparam int              CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(LOCK_MAX);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_LOCK0 = 2'd1,
    OWN_LOCK1 = 2'd2
  } owner_t;

  owner_t                  r_owner;
  logic [CW-1:0]           r_lock_cnt;
  logic                    r_rvalid0;
  logic                    r_rvalid1;
  logic [WORD_SIZE-1:0]    r_rdata0;
  logic [WORD_SIZE-1:0]    r_rdata1;

  logic                    w_gnt0;
  logic                    w_gnt1;
  logic                    w_cnt_full;
  logic                    w_tie_to1;
  logic [ADDRESS_SIZE-1:0] w_mem_addr;
  logic [WORD_SIZE-1:0]    w_mem_w_data;
  logic                    w_mem_w_en;

  assign w_cnt_full = (r_lock_cnt == CNT_MAX);

`ifdef ARB_FIXED_PRIO_EN
  // One-shot priority token for requester 1 after a forced release of LOCK0.
  logic r_prio1;

  assign w_tie_to1 = r_prio1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio1 <= 1'b0;
    end else if (w_gnt1) begin
      r_prio1 <= 1'b0;
    end else if (r_owner == OWN_LOCK0 && w_cnt_full) begin
      r_prio1 <= 1'b1;
    end
  end
`else
  logic r_last;

  assign w_tie_to1 = ~r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
    end else if (r_owner == OWN_LOCK0 && w_cnt_full) begin
      r_last <= 1'b0;
    end else if (r_owner == OWN_LOCK1 && w_cnt_full) begin
      r_last <= 1'b1;
    end
  end
`endif

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_owner)
      OWN_NONE: begin
        if (bus.req0 && bus.req1) begin
          w_gnt1 = w_tie_to1;
          w_gnt0 = ~w_tie_to1;
        end else begin
          w_gnt0 = bus.req0;
          w_gnt1 = bus.req1;
        end
      end
      OWN_LOCK0: w_gnt0 = bus.req0 & ~w_cnt_full;
      OWN_LOCK1: w_gnt1 = bus.req1 & ~w_cnt_full;
      default: ;
    endcase
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  always_comb begin
    w_mem_addr   = '0;
    w_mem_w_data = '0;
    w_mem_w_en   = 1'b0;
    if (w_gnt0) begin
      w_mem_addr   = bus.addr0;
      w_mem_w_data = bus.wdata0;
      w_mem_w_en   = bus.we0;
    end else if (w_gnt1) begin
      w_mem_addr   = bus.addr1;
      w_mem_w_data = bus.wdata1;
      w_mem_w_en   = bus.we1;
    end
  end

  // Locked idle cycles count toward the limit as well, so the counter is the plain
  // tenure length; it stops at CNT_MAX because that cycle always releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_NONE;
      r_lock_cnt <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~bus.we0;
      r_rvalid1 <= w_gnt1 & ~bus.we1;
      if (w_gnt0 && !bus.we0) r_rdata0 <= bus.mem_r_data;
      if (w_gnt1 && !bus.we1) r_rdata1 <= bus.mem_r_data;

      case (r_owner)
        OWN_NONE: begin
          if (w_gnt0 && bus.lock0) begin
            r_owner    <= OWN_LOCK0;
            r_lock_cnt <= CW'(1);
          end else if (w_gnt1 && bus.lock1) begin
            r_owner    <= OWN_LOCK1;
            r_lock_cnt <= CW'(1);
          end
        end
        OWN_LOCK0: begin
          if (!w_cnt_full && bus.lock0) begin
            r_lock_cnt <= r_lock_cnt + CW'(1);
          end else begin
            r_owner    <= OWN_NONE;
            r_lock_cnt <= '0;
          end
        end
        OWN_LOCK1: begin
          if (!w_cnt_full && bus.lock1) begin
            r_lock_cnt <= r_lock_cnt + CW'(1);
          end else begin
            r_owner    <= OWN_NONE;
            r_lock_cnt <= '0;
          end
        end
        default: begin
          r_owner    <= OWN_NONE;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.gnt0       = w_gnt0;
  assign bus.gnt1       = w_gnt1;
  assign bus.rvalid0    = r_rvalid0;
  assign bus.rvalid1    = r_rvalid1;
  assign bus.rdata0     = r_rdata0;
  assign bus.rdata1     = r_rdata1;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_w_data = w_mem_w_data;
  assign bus.mem_w_en   = w_mem_w_en;

endmodule
